// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
//   Shared types and constants for the interrupt sequencer.
//
//   Contents:
//     NUM_SRC_DEF  default number of interrupt sources
//     IRQ_TIMER    source index of the timer overflow interrupt
//     IRQ_EXT      source index of the external interrupt line
//     irq_state_e  sequencer state (IDLE, REQ, SERVICE)
//     id_width()   width of a source id for a given source count
//
//   Build option: IRQ_ROUND_ROBIN_EN (see irq_sequencer) selects rotating
//   priority; nothing in this package depends on it.
// -----------------------------------------------------------------------------
package irq_pkg;

  localparam int unsigned NUM_SRC_DEF = 4;

  localparam int unsigned IRQ_TIMER = 0;
  localparam int unsigned IRQ_EXT   = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // A single source still needs a 1-bit id.
  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_picker.sv
// -----------------------------------------------------------------------------
// irq_prio_picker
//   Combinational winner selection among eligible interrupt sources.
//   The search begins at index 'start' and wraps modulo NUM_SRC; the first
//   eligible index found wins. With start tied to 0 this is plain fixed
//   priority (lowest index wins).
//
//   Ports:
//     eligible  in   NUM_SRC  candidate sources
//     start     in   ID_W     first index examined
//     valid     out  1        at least one source eligible
//     id        out  ID_W     winning source (0 when valid=0)
// -----------------------------------------------------------------------------
module irq_prio_picker
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned ID_W    = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [ID_W-1:0]    start,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  logic [ID_W-1:0] idx;

  assign valid = |eligible;

  // Walk from the far end back towards 'start' so the last hit, i.e. the
  // one closest to 'start', is the one that sticks.
  always_comb begin
    id  = '0;
    idx = '0;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      idx = ID_W'((int'(start) + k) % int'(NUM_SRC));
      if (eligible[idx]) begin
        id = idx;
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
//   Captures interrupt sources into a pending register, selects one winner
//   and presents it to the datapath through a req/ack handshake. After the
//   trap is taken no further request is issued until mret retires
//   (irq_done). The one-hot 'interrupt' bus mirrors irq_id while irq_req=1.
//
//   Build option:
//     IRQ_ROUND_ROBIN_EN  defined: rotating priority, search starts one past
//                         the last acknowledged source.
//                         undefined: fixed priority, lowest index wins.
//
//   Ports:
//     clk         in   1        core clock
//     rst         in   1        synchronous active-high reset
//     src_i       in   NUM_SRC  raw interrupt source lines
//     edge_mode   in   NUM_SRC  1 = rising-edge triggered, 0 = level
//     src_en      in   NUM_SRC  per-source enable mask (mie)
//     global_ie   in   1        global interrupt enable (mstatus.MIE)
//     irq_ack     in   1        datapath took the trap for irq_id (pulse)
//     irq_done    in   1        mret retired (pulse)
//     irq_req     out  1        interrupt request to datapath
//     irq_id      out  ID_W     requested or in-service source id
//     interrupt   out  NUM_SRC  one-hot of irq_id while irq_req=1, else 0
//     pending     out  NUM_SRC  pending register (mip view)
//     in_service  out  1        handler active
// -----------------------------------------------------------------------------
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned ID_W    = id_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               global_ie,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] interrupt,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service
);

  irq_state_e         state_q;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] pending_d;
  logic [ID_W-1:0]    start_ptr;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic               withdraw;
  logic               take;

  assign rise     = src_i & ~src_q;
  assign eligible = global_ie ? (pending & src_en) : '0;

  // The presented request is no longer valid; checked ahead of irq_ack.
  assign withdraw = !global_ie || !src_en[irq_id] || !pending[irq_id];
  assign take     = (state_q == REQ) && irq_ack && !withdraw;

  // Edge sources accumulate and are cleared on acknowledge, with a fresh
  // edge in the same cycle winning over the clear. Level sources simply
  // track the line.
  always_comb begin
    ack_clr = '0;
    if (take && edge_mode[irq_id]) begin
      ack_clr[irq_id] = 1'b1;
    end
    pending_d = (edge_mode & ((pending & ~ack_clr) | rise)) | (~edge_mode & src_i);
  end

`ifdef IRQ_ROUND_ROBIN_EN
  // Start of the next search: one past the most recently acknowledged id.
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= ID_W'((int'(irq_id) + 1) % int'(NUM_SRC));
    end
  end

  assign start_ptr = rr_ptr;
`else
  assign start_ptr = '0;
`endif

  irq_prio_picker #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_picker (
    .eligible (eligible),
    .start    (start_ptr),
    .valid    (win_valid),
    .id       (win_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      pending    <= '0;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      interrupt  <= '0;
      in_service <= 1'b0;
    end else begin
      src_q   <= src_i;
      pending <= pending_d;
      unique case (state_q)
        IDLE: begin
          if (win_valid) begin
            irq_id    <= win_id;
            irq_req   <= 1'b1;
            interrupt <= NUM_SRC'(1) << win_id;
            state_q   <= REQ;
          end
        end
        REQ: begin
          // irq_id stays frozen here; later arrivals never preempt it.
          if (withdraw) begin
            irq_req   <= 1'b0;
            interrupt <= '0;
            state_q   <= IDLE;
          end else if (irq_ack) begin
            irq_req    <= 1'b0;
            interrupt  <= '0;
            in_service <= 1'b1;
            state_q    <= SERVICE;
          end
        end
        SERVICE: begin
          if (irq_done) begin
            in_service <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_sequencer
//   Directed scenarios followed by randomized stimulus. Each cycle the
//   reference model predicts the outputs after the next clock edge and
//   queues them; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_irq_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] src_i;
  logic [3:0] edge_mode;
  logic [3:0] src_en;
  logic       global_ie;
  logic       irq_ack;
  logic       irq_done;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [3:0] interrupt;
  logic [3:0] pending;
  logic       in_service;

  irq_sequencer #(
    .NUM_SRC (4),
    .ID_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_i      (src_i),
    .edge_mode  (edge_mode),
    .src_en     (src_en),
    .global_ie  (global_ie),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .interrupt  (interrupt),
    .pending    (pending),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic [1:0] id;
    logic [3:0] intr;
    logic [3:0] pend;
    logic       serv;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: what the sequencer is doing, in plain terms.
  logic [3:0] m_last_src;  // line values seen on the previous edge
  logic [3:0] m_pend;
  int         m_phase;     // 0 waiting, 1 requesting, 2 handler running
  logic       m_req;
  logic [1:0] m_id;
  logic       m_serv;
  logic [1:0] m_next_start;

  function automatic logic [1:0] pick(logic [3:0] el);
    logic [1:0] s;
    logic [1:0] ix;
    s = 2'd0;
`ifdef IRQ_ROUND_ROBIN_EN
    s = m_next_start;
`endif
    for (int k = 0; k < 4; k++) begin
      ix = s + 2'(k);
      if (el[ix]) return ix;
    end
    return 2'd0;
  endfunction

  task automatic model_step();
    logic [3:0] rise;
    logic [3:0] elig;
    logic [3:0] npend;
    exp_t       e;
    if (rst) begin
      m_last_src   = 4'h0;
      m_pend       = 4'h0;
      m_phase      = 0;
      m_req        = 1'b0;
      m_id         = 2'd0;
      m_serv       = 1'b0;
      m_next_start = 2'd0;
    end else begin
      rise = src_i & ~m_last_src;
      elig = global_ie ? (m_pend & src_en) : 4'h0;
      for (int i = 0; i < 4; i++) begin
        npend[i] = edge_mode[i] ? (m_pend[i] | rise[i]) : src_i[i];
      end
      if (m_phase == 0) begin
        if (elig != 4'h0) begin
          m_id    = pick(elig);
          m_req   = 1'b1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!global_ie || !src_en[m_id] || !m_pend[m_id]) begin
          m_req   = 1'b0;
          m_phase = 0;
        end else if (irq_ack) begin
          m_req        = 1'b0;
          m_serv       = 1'b1;
          m_phase      = 2;
          m_next_start = m_id + 2'd1;
          if (edge_mode[m_id] && !rise[m_id]) npend[m_id] = 1'b0;
        end
      end else begin
        if (irq_done) begin
          m_serv  = 1'b0;
          m_phase = 0;
        end
      end
      m_last_src = src_i;
      m_pend     = npend;
    end
    e.req  = m_req;
    e.id   = m_id;
    e.intr = m_req ? (4'b0001 << m_id) : 4'h0;
    e.pend = m_pend;
    e.serv = m_serv;
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs settle after the rising edge, compare on the falling one.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("irq_req",    {7'd0, irq_req},    {7'd0, e.req});
      chk("irq_id",     {6'd0, irq_id},     {6'd0, e.id});
      chk("interrupt",  {4'd0, interrupt},  {4'd0, e.intr});
      chk("pending",    {4'd0, pending},    {4'd0, e.pend});
      chk("in_service", {7'd0, in_service}, {7'd0, e.serv});
    end
  end

  // Predict the outcome of the current inputs, then move to the next cycle.
  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    src_i     = 4'h0;
    edge_mode = 4'b0011;
    src_en    = 4'hF;
    global_ie = 1'b1;
    irq_ack   = 1'b0;
    irq_done  = 1'b0;
    step();
    rst = 1'b0;

    // Edge capture on source 1: request at cycle 2, ack at 4, done at 8.
    src_i = 4'b0010;
    steps(4);
    pulse_ack();
    steps(3);
    pulse_done();
    steps(2);
    src_i = 4'b0000;
    steps(2);

    // Level source 2 granted, then source 0 rises while 2 is presented.
    src_i = 4'b0100;
    steps(3);
    src_i = 4'b0101;
    steps(3);
    pulse_ack();
    src_i = 4'b0001;
    steps(2);
    pulse_done();
    steps(3);
    pulse_ack();
    pulse_done();
    src_i = 4'b0000;
    steps(2);

    // Withdraw by global_ie, then re-request of the same id.
    src_i = 4'b0010;
    steps(3);
    global_ie = 1'b0;
    steps(2);
    global_ie = 1'b1;
    steps(3);
    pulse_ack();
    pulse_done();
    src_i = 4'b0000;
    steps(2);

    // Level source 3 held through ack and done re-requests.
    src_i = 4'b1000;
    steps(3);
    pulse_ack();
    steps(2);
    pulse_done();
    steps(4);
    src_i = 4'b0000;
    steps(2);

    // New edge on source 0 in the same cycle as its ack, then mid-service reset.
    src_i = 4'b0001;
    steps(3);
    src_i = 4'b0000;
    step();
    src_i   = 4'b0001;
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    steps(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(2);

    // Round-robin style traffic: sources 0 and 1 re-triggered every service.
    edge_mode = 4'b0011;
    for (int r = 0; r < 6; r++) begin
      src_i = 4'b0011;
      steps(3);
      pulse_ack();
      src_i = 4'b0000;
      step();
      pulse_done();
    end
    steps(3);

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      if (c % 300 == 0) edge_mode = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) src_i[i] = ~src_i[i];
      end
      if ($urandom_range(0, 19) == 0) src_en = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) global_ie = ~global_ie;
      irq_ack  = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      irq_done = (m_phase == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
      rst      = ($urandom_range(0, 399) == 0);
      step();
    end
    rst      = 1'b0;
    irq_ack  = 1'b0;
    irq_done = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("drain", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Replaces the fixed combinational interrupt mux at the core top.
- Captures interrupt sources (timer overflow, external line, spares), holds them as pending, and picks one winner.
- Presents the winner to the datapath/CSR unit through a req/ack handshake, then blocks further requests until the handler executes mret.
- Keeps the existing one-hot 4-bit interrupt bus to the datapath.

Parameters:
- NUM_SRC, 4, number of interrupt sources; index 0 is highest priority (0 = timer ovf, 1 = ext_inter).
- ID_W, $clog2(NUM_SRC), width of the source id.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, synchronous, active-high
- src_i  in  NUM_SRC  raw interrupt source lines
- edge_mode  in  NUM_SRC  per source: 1 = rising-edge triggered, 0 = level
- src_en  in  NUM_SRC  per-source enable mask (mie)
- global_ie  in  1  global interrupt enable (mstatus.MIE)
- irq_ack  in  1  datapath has taken the trap for the presented id (single-cycle pulse)
- irq_done  in  1  mret retired (single-cycle pulse)
- irq_req  out  1  interrupt request to datapath
- irq_id  out  ID_W  id of the requested or in-service source
- interrupt  out  NUM_SRC  one-hot of irq_id while irq_req=1, else 0
- pending  out  NUM_SRC  pending register (CSR mip view)
- in_service  out  1  handler active

Behaviour:
- Reset: state IDLE; all of the following are 0: pending, src_q, irq_req, irq_id, interrupt, in_service, rr pointer.
- Capture:
  - src_q <= src_i every cycle.
  - Edge source: pending set when src_i & ~src_q.
  - Level source: pending[i] <= src_i[i] every cycle.
- Eligible set = pending & src_en, gated by global_ie.
- FSM, states IDLE, REQ, SERVICE:
  - IDLE: if the eligible set is non-zero, register winner into irq_id, set irq_req=1, go to REQ. irq_ack and irq_done are ignored.
  - REQ: irq_id is frozen; a higher-priority arrival does not preempt it.
    - Withdraw (irq_req=0, go to IDLE, no clear) if global_ie=0, src_en[irq_id]=0, or pending[irq_id]=0 (level source dropped).
    - On irq_ack: go to SERVICE, irq_req=0, in_service=1. If the source is edge-mode, clear pending[irq_id].
    - Withdraw conditions take priority over an irq_ack in the same cycle.
  - SERVICE: no requests are issued; pending keeps accumulating. On irq_done: in_service=0, go to IDLE. irq_id holds its value until the next grant.
- Latency: src_i rising, sampled at edge E0 → pending=1 after E0 → irq_req=1 after E1 (2 cycles). After irq_done at edge E, a queued request reappears after E+1 at the earliest.
- Simultaneous edge and ack clear on the same edge source: the set wins, so the new event stays pending.
- No nesting: irq_done while not in SERVICE is ignored.
- A level source that stays asserted after mret re-requests.
- Reset mid-operation: returns to the reset state next cycle; all pending events are lost.
- interrupt output = irq_req ? (1 << irq_id) : 0.

Optional Feature:
- Macro IRQ_ROUND_ROBIN_EN.
- Defined: rotating priority. The search starts at (last_granted+1) mod NUM_SRC; last_granted updates on irq_ack.
- Undefined: fixed priority, lowest index wins; the pointer is not built.
- All other behaviour is identical in both builds.

Decomposition:
- Package irq_pkg holds:
  - the irq_state_e enum (IDLE, REQ, SERVICE);
  - constants IRQ_TIMER=0 and IRQ_EXT=1;
  - the default NUM_SRC.
- One combinational sub-module, irq_prio_picker, maps (eligible vector, start pointer) to (valid, id). Fixed-priority mode ties the start pointer to 0.

Test Plan:
- Edge capture: src_i[1] held high from cycle 0, edge_mode=4'b0011, src_en=4'hF, global_ie=1 → irq_req=1, irq_id=1, interrupt=4'b0010 at cycle 2. irq_ack at cycle 4 → pending[1]=0, in_service=1. irq_done at 8 → IDLE.
- Priority and freeze: src 2 granted (REQ), then src 0 rises → irq_id stays 2 until ack. After irq_done, src 0 is requested 2 cycles later.
- Withdraw: in REQ, drop global_ie → irq_req=0 next cycle, pending unchanged. Restore global_ie → same id re-requested.
- Level re-request: level src 3 held high through ack and done → irq_req=1 again 2 cycles after irq_done.
- Simultaneous edge and ack: new rising edge on src 0 in the same cycle as irq_ack for src 0 → pending[0]=1 after the edge. Mid-SERVICE rst=1 → all outputs 0 next cycle.
- Round-robin (IRQ_ROUND_ROBIN_EN): sources 0 and 1 pending continuously, edge mode, re-triggered each service → grants alternate 0, 1, 0, 1.
